// File: rtl/nibble_acc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nibble_acc_pkg                                                             |
// | Shared types and sizing helpers for the nibble sum accumulator.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package nibble_acc_pkg;

  // Adder result term: {carry_out, sum[3:0]}
  localparam int TERM_W = 5;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  // Counter width able to represent 0..frame_len inclusive.
  function automatic int cnt_w(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_acc_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nibble_acc_datapath                                                        |
// | Frame accumulator, sticky overflow flag and term counter.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nibble_acc_datapath
  import nibble_acc_pkg::*;
#(
  parameter int ACC_W = 8,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic [TERM_W-1:0] term,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf,
  output logic [CNT_W-1:0]  count
);

  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [CNT_W-1:0] r_count;
  logic [ACC_W:0]   w_sum;

  // One extra bit on the adder exposes the carry-out that feeds the sticky flag.
  assign w_sum = {1'b0, r_acc} + (ACC_W + 1)'(term);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else if (clr) begin
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else if (load) begin
      r_acc   <= w_sum[ACC_W-1:0];
      r_ovf   <= r_ovf | w_sum[ACC_W];
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign acc   = r_acc;
  assign ovf   = r_ovf;
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/nibble_sum_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nibble_sum_accumulator                                                     |
// | Sums FRAME_LEN adder results per frame; hands the total out via ready/valid.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nibble_sum_accumulator
  import nibble_acc_pkg::*;
#(
  parameter  int ACC_W     = 8,
  parameter  int FRAME_LEN = 16,
  localparam int CNT_W     = cnt_w(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_sum,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(FRAME_LEN - 1);

  state_t r_state;
  state_t w_next_state;
  logic   w_accept;
  logic   w_out_fire;
  logic   w_dp_clr;
  logic   w_last;

  // in_ready / out_valid decode the state register only.
  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == DONE);

  // clear masks both handshakes so a flush never counts as a transfer.
  assign w_accept   = in_valid & in_ready & ~clear;
  assign w_out_fire = out_valid & out_ready & ~clear;
  assign w_dp_clr   = clear | w_out_fire;
  assign w_last     = (out_count == C_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = ACCUM;
    end else begin
      case (r_state)
        ACCUM: if (w_accept && w_last) w_next_state = DONE;
        DONE:  if (w_out_fire)         w_next_state = ACCUM;
        default: w_next_state = ACCUM;
      endcase
    end
  end

  nibble_acc_datapath #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_datapath (
    .clk   (clk),
    .rst   (rst),
    .load  (w_accept),
    .clr   (w_dp_clr),
    .term  ({in_carry, in_sum}),
    .acc   (out_acc),
    .ovf   (out_ovf),
    .count (out_count)
  );

endmodule
`default_nettype wire
